sync_mode_counter: RTL and testbench



---
 rtl/sync_mode_counter.sv | 143 ++++++++++++++
 tb/tb_sync_mode_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_mode_counter.sv
// sync_mode_counter
//   Synchronous multi-mode counter producing binary up (modulo MOD), binary
//   down (modulo MOD), Gray and Johnson sequences. It has a synchronous clear, a
//   parallel load, a combinational terminal-count strobe and a saturating wrap
//   counter.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   en        count enable
//   clr       synchronous clear to the seed of the current mode (also zeroes wraps)
//   load      synchronous parallel load
//   load_val  load value (binary index)
//   mode      00 BIN_UP, 01 BIN_DOWN, 10 GRAY, 11 JOHNSON
//   q         counter output, encoded per mode
//   tc        terminal-count strobe (combinational)
//   wraps     wraps since reset/clear, saturating at all-ones
//   load_err  one-cycle pulse following an illegal load
module sync_mode_counter #(
  parameter int WIDTH    = 3,
  parameter int MOD      = 8,
  parameter int RST_MODE = 0,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic [WRAP_W-1:0] wraps,
  output logic              load_err
);

  typedef enum logic [1:0] {
    BIN_UP   = 2'b00,
    BIN_DOWN = 2'b01,
    GRAY     = 2'b10,
    JOHNSON  = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MOD_M1   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] J_TERM   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam mode_e            RST_M    = mode_e'(RST_MODE[1:0]);

  // In GRAY mode cnt holds the binary index; q is its Gray encoding.
  // In all other modes cnt is exactly what appears on q.
  mode_e             mode_r, mode_n;
  logic [WIDTH-1:0]  cnt, cnt_n;
  logic [WRAP_W-1:0] wraps_n;
  logic              err_n;
  logic              mode_chg;
  logic              term;

  function automatic logic [WIDTH-1:0] seed(input mode_e m);
    return (m == BIN_DOWN) ? MOD_M1 : '0;
  endfunction

  // A legal Johnson word has at most one transition between adjacent bits.
  function automatic logic johnson_legal(input logic [WIDTH-1:0] c);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (c[i] != c[i+1]) n++;
    end
    return (n <= 1);
  endfunction

  function automatic logic [WIDTH-1:0] step(input mode_e m, input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    case (m)
      BIN_UP:   r = (c == MOD_M1) ? '0 : c + 1'b1;
      BIN_DOWN: r = (c == '0) ? MOD_M1 : c - 1'b1;
      GRAY:     r = c + 1'b1;
      default:  r = johnson_legal(c) ? {c[WIDTH-2:0], ~c[WIDTH-1]} : '0;
    endcase
    return r;
  endfunction

  assign mode_chg = (mode_e'(mode) != mode_r);

  always_comb begin
    term = 1'b0;
    case (mode_r)
      BIN_UP:   term = (cnt == MOD_M1);
      BIN_DOWN: term = (cnt == '0);
      GRAY:     term = (cnt == '1);
      default:  term = (cnt == J_TERM);
    endcase
  end

  assign tc = en & term & ~clr & ~load & ~mode_chg;
  assign q  = (mode_r == GRAY) ? (cnt ^ (cnt >> 1)) : cnt;

  always_comb begin
    mode_n  = mode_r;
    cnt_n   = cnt;
    wraps_n = wraps;
    err_n   = 1'b0;
    if (clr) begin
      cnt_n   = seed(mode_r);
      wraps_n = '0;
    end else if (mode_chg) begin
      // en and load are deliberately dropped in the cycle the mode switches.
      mode_n = mode_e'(mode);
      cnt_n  = seed(mode_e'(mode));
    end else if (load) begin
      case (mode_r)
        BIN_UP, BIN_DOWN: begin
          if (load_val > MOD_M1) begin
            cnt_n = MOD_M1;
            err_n = 1'b1;
          end else begin
            cnt_n = load_val;
          end
        end
        GRAY:    cnt_n = load_val;
        default: err_n = 1'b1;
      endcase
    end else if (en) begin
      cnt_n = step(mode_r, cnt);
      if (tc && (wraps != '1)) wraps_n = wraps + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r   <= RST_M;
      cnt      <= seed(RST_M);
      wraps    <= '0;
      load_err <= 1'b0;
    end else begin
      mode_r   <= mode_n;
      cnt      <= cnt_n;
      wraps    <= wraps_n;
      load_err <= err_n;
    end
  end

endmodule

// File: tb/tb_sync_mode_counter.sv
// Bench for sync_mode_counter with WIDTH=3, MOD=6, RST_MODE=0, WRAP_W=8.
module tb_sync_mode_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic       load;
  logic [2:0] load_val;
  logic [1:0] mode;
  logic [2:0] q;
  logic       tc;
  logic [7:0] wraps;
  logic       load_err;

  int checks   = 0;
  int failures = 0;

  sync_mode_counter #(.WIDTH(3), .MOD(6), .RST_MODE(0), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .mode(mode), .q(q), .tc(tc), .wraps(wraps), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; mode = 2'b00;
    #2;
    checks++;
    if (q !== 3'd0) begin failures++; $display("FAIL reset_q actual=%0d expected=0", q); end
    checks++;
    if (wraps !== 8'd0) begin failures++; $display("FAIL reset_wraps actual=%0d expected=0", wraps); end
    checks++;
    if (load_err !== 1'b0) begin failures++; $display("FAIL reset_err actual=%b expected=0", load_err); end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_bin_up();
    en = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q !== 3'(i % 6)) begin failures++; $display("FAIL up_q[%0d] actual=%0d expected=%0d", i, q, i % 6); end
      checks++;
      if (tc !== ((i % 6) == 5)) begin failures++; $display("FAIL up_tc[%0d] actual=%b expected=%b", i, tc, (i % 6) == 5); end
      step();
    end
    checks++;
    if (wraps !== 8'd1) begin failures++; $display("FAIL up_wraps actual=%0d expected=1", wraps); end
  endtask

  task automatic test_bin_down();
    logic [2:0] exp_q [7] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
    mode = 2'b01;
    #1;
    checks++;
    if (tc !== 1'b0) begin failures++; $display("FAIL down_chg_tc actual=%b expected=0", tc); end
    step();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (q !== exp_q[i]) begin failures++; $display("FAIL down_q[%0d] actual=%0d expected=%0d", i, q, exp_q[i]); end
      checks++;
      if (tc !== (exp_q[i] == 3'd0)) begin failures++; $display("FAIL down_tc[%0d] actual=%b expected=%b", i, tc, exp_q[i] == 3'd0); end
      step();
    end
    checks++;
    if (wraps !== 8'd2) begin failures++; $display("FAIL down_wraps actual=%0d expected=2", wraps); end
  endtask

  task automatic test_load();
    en = 1'b0; mode = 2'b00;
    step();
    checks++;
    if (q !== 3'd0) begin failures++; $display("FAIL load_seed actual=%0d expected=0", q); end
    load = 1'b1; load_val = 3'd7;
    step();
    checks++;
    if (q !== 3'd5) begin failures++; $display("FAIL load_clamp_q actual=%0d expected=5", q); end
    checks++;
    if (load_err !== 1'b1) begin failures++; $display("FAIL load_err7 actual=%b expected=1", load_err); end
    load_val = 3'd2;
    step();
    checks++;
    if (q !== 3'd2) begin failures++; $display("FAIL load2_q actual=%0d expected=2", q); end
    checks++;
    if (load_err !== 1'b0) begin failures++; $display("FAIL load2_err actual=%b expected=0", load_err); end
    load_val = 3'd6;
    step();
    checks++;
    if ((q !== 3'd5) || (load_err !== 1'b1)) begin
      failures++; $display("FAIL load6 actual q=%0d err=%b expected q=5 err=1", q, load_err);
    end
    load_val = 3'd5;
    step();
    checks++;
    if ((q !== 3'd5) || (load_err !== 1'b0)) begin
      failures++; $display("FAIL load5 actual q=%0d err=%b expected q=5 err=0", q, load_err);
    end
    load = 1'b0;
    step();
    checks++;
    if ((q !== 3'd5) || (load_err !== 1'b0)) begin
      failures++; $display("FAIL hold actual q=%0d err=%b expected q=5 err=0", q, load_err);
    end
  endtask

  task automatic test_gray();
    logic [2:0] exp_q [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    mode = 2'b10; en = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (q !== exp_q[i]) begin failures++; $display("FAIL gray_q[%0d] actual=%b expected=%b", i, q, exp_q[i]); end
      checks++;
      if (tc !== (i == 7)) begin failures++; $display("FAIL gray_tc[%0d] actual=%b expected=%b", i, tc, i == 7); end
      step();
    end
    checks++;
    if (wraps !== 8'd3) begin failures++; $display("FAIL gray_wraps actual=%0d expected=3", wraps); end
    en = 1'b0; load = 1'b1; load_val = 3'd6;
    step();
    load = 1'b0;
    checks++;
    if ((q !== 3'b101) || (load_err !== 1'b0)) begin
      failures++; $display("FAIL gray_load actual q=%b err=%b expected q=101 err=0", q, load_err);
    end
  endtask

  task automatic test_johnson();
    logic [2:0] exp_q [7] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
    mode = 2'b11; en = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (q !== exp_q[i]) begin failures++; $display("FAIL john_q[%0d] actual=%b expected=%b", i, q, exp_q[i]); end
      checks++;
      if (tc !== (i == 5)) begin failures++; $display("FAIL john_tc[%0d] actual=%b expected=%b", i, tc, i == 5); end
      step();
    end
    checks++;
    if (wraps !== 8'd4) begin failures++; $display("FAIL john_wraps actual=%0d expected=4", wraps); end
    en = 1'b0; load = 1'b1; load_val = 3'd3;
    step();
    checks++;
    if ((q !== 3'b001) || (load_err !== 1'b1)) begin
      failures++; $display("FAIL john_load actual q=%b err=%b expected q=001 err=1", q, load_err);
    end
    load = 1'b0;
    step();
    checks++;
    if (load_err !== 1'b0) begin failures++; $display("FAIL john_err_pulse actual=%b expected=0", load_err); end
  endtask

  task automatic test_back_to_back();
    // clear and load together in JOHNSON: clear wins, no load error
    en = 1'b1; clr = 1'b1; load = 1'b1; load_val = 3'd7;
    #1;
    checks++;
    if (tc !== 1'b0) begin failures++; $display("FAIL clr_tc actual=%b expected=0", tc); end
    step();
    clr = 1'b0;
    checks++;
    if ((q !== 3'd0) || (wraps !== 8'd0) || (load_err !== 1'b0)) begin
      failures++; $display("FAIL clr_load actual q=%0d w=%0d err=%b expected q=0 w=0 err=0", q, wraps, load_err);
    end
    // mode change with an illegal load: load dropped, no error
    mode = 2'b00;
    step();
    load = 1'b0;
    checks++;
    if ((q !== 3'd0) || (load_err !== 1'b0)) begin
      failures++; $display("FAIL chg_load actual q=%0d err=%b expected q=0 err=0", q, load_err);
    end
    // reset mid-count in BIN_DOWN
    mode = 2'b01;
    step(); step(); step();
    checks++;
    if (q !== 3'd3) begin failures++; $display("FAIL pre_rst_q actual=%0d expected=3", q); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 3'd0) begin failures++; $display("FAIL async_rst_q actual=%0d expected=0", q); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b0) begin failures++; $display("FAIL rst_mode_tc actual=%b expected=0", tc); end
    step();
    checks++;
    if (q !== 3'd5) begin failures++; $display("FAIL post_rst_q actual=%0d expected=5", q); end
  endtask

  task automatic test_saturation();
    mode = 2'b00; en = 1'b0; clr = 1'b1;
    step();
    step();
    clr = 1'b0; en = 1'b1;
    for (int i = 0; i < 6 * 256 + 2; i++) step();
    checks++;
    if (wraps !== 8'd255) begin failures++; $display("FAIL wraps_sat actual=%0d expected=255", wraps); end
  endtask

  initial begin
    test_reset();
    test_bin_up();
    test_bin_down();
    test_load();
    test_gray();
    test_johnson();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
